sipo_deserializer: RTL and testbench

Serial-in, parallel-out receiver. It is the far end of the team's 4-bit PISO shift-register link: it samples one serial bit per clock while shift is high and assembles WIDTH-bit words. Each completed word is presented on a held parallel bus with a valid/ready handshake. Overruns are flagged, and a resync input realigns word boundaries.

---
 rtl/sipo_deserializer.sv | 83 ++++++++
 tb/tb_sipo_deserializer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_deserializer
//  Description : Serial-in, parallel-out receiver. Collects one bit per clock
//                while shift is high, LSB first, and presents each completed
//                WIDTH-bit word on a held bus with a valid/ready handshake.
//                A sticky overrun flag records words completed on top of an
//                unconsumed word; resync realigns the word boundary.
//  Revision    : 1.0 - initial release
// ============================================================================
module sipo_deserializer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             shift,
    input  logic             resync,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    input  logic             ready,
    output logic             overrun,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_q;
    logic             r_valid;
    logic             r_overrun;
    logic [CNT_W-1:0] r_bit_cnt;

    logic [WIDTH-1:0] w_sr_next;
    logic             w_take_bit;
    logic             w_complete;

    // New bits enter at the top so the first-received bit ends up in bit 0.
    assign w_sr_next  = {din, r_sr[WIDTH-1:1]};
    // resync wins over shift: a bit presented on a resync edge is dropped.
    assign w_take_bit = shift && !resync;
    assign w_complete = w_take_bit && (r_bit_cnt == c_last_bit);

    // Shift register, bit counter, output word and handshake flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr      <= '0;
            r_q       <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_bit_cnt <= '0;
        end else begin
            if (resync) begin
                r_sr      <= '0;
                r_bit_cnt <= '0;
            end else if (shift) begin
                r_sr      <= w_sr_next;
                r_bit_cnt <= w_complete ? '0 : (r_bit_cnt + c_one);
            end

            // A completing word always lands in q; the old word is only lost
            // (and flagged) when it was not being accepted on this same edge.
            if (w_complete) begin
                r_q     <= w_sr_next;
                r_valid <= 1'b1;
                if (r_valid && !ready) begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign q       = r_q;
    assign valid   = r_valid;
    assign overrun = r_overrun;
    assign bit_cnt = r_bit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sipo_deserializer
//  Description : Randomised and directed bench for sipo_deserializer with a
//                bit-list reference model and a word scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_deserializer;

    localparam int WIDTH = 4;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             din = 1'b0;
    logic             shift = 1'b0;
    logic             resync = 1'b0;
    logic             ready = 1'b0;
    logic [WIDTH-1:0] q;
    logic             valid;
    logic             overrun;
    logic [CNT_W-1:0] bit_cnt;

    sipo_deserializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .shift   (shift),
        .resync  (resync),
        .q       (q),
        .valid   (valid),
        .ready   (ready),
        .overrun (overrun),
        .bit_cnt (bit_cnt)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The model keeps the bits of the current partial word as a list and the
    // queue of words the consumer should still receive.
    bit               m_bits[$];
    logic [31:0]      m_expq[$];
    bit               m_valid   = 1'b0;
    bit               m_overrun = 1'b0;
    bit               m_qzero   = 1'b1;
    bit               m_armed   = 1'b0;

    // Update the model with the inputs present at each rising edge.
    always @(posedge clk) begin
        logic [31:0] w;
        if (rst) begin
            m_bits.delete();
            m_expq.delete();
            m_valid   = 1'b0;
            m_overrun = 1'b0;
            m_qzero   = 1'b1;
            m_armed   = 1'b1;
        end else begin
            if (m_valid && ready) m_valid = 1'b0;
            if (resync) begin
                m_bits.delete();
            end else if (shift) begin
                m_bits.push_back(din);
                if (m_bits.size() == WIDTH) begin
                    w = '0;
                    for (int i = 0; i < WIDTH; i++) w[i] = m_bits[i];
                    m_bits.delete();
                    if (m_valid) begin
                        // previous word was never taken: it is lost
                        if (m_expq.size() > 0) void'(m_expq.pop_back());
                        m_overrun = 1'b1;
                    end
                    m_expq.push_back(w);
                    m_valid = 1'b1;
                    m_qzero = 1'b0;
                end
            end
        end
    end

    // Monitor: compare DUT outputs against the model on the falling edge and
    // retire scoreboard words when a handshake is about to happen.
    always @(negedge clk) begin
        if (m_armed) begin
            chk("valid",   32'(valid),   32'(m_valid));
            chk("overrun", 32'(overrun), 32'(m_overrun));
            chk("bit_cnt", 32'(bit_cnt), 32'(m_bits.size()));
            if (m_qzero) chk("q_reset", 32'(q), 32'd0);
            if (valid) begin
                if (m_expq.size() == 0) begin
                    chk("q_no_expected_word", 32'(q), 32'hFFFF_FFFF);
                end else begin
                    chk("q_word", 32'(q), m_expq[0]);
                    if (ready && !rst) void'(m_expq.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic r, input logic s, input logic d,
                       input logic rs, input logic rd);
        rst = r; shift = s; din = d; resync = rs; ready = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] bits, input logic rd);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, bits[i], 1'b0, rd);
    endtask

    initial begin
        // Plan 1: reset with shifting activity
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_cnt", 32'(bit_cnt), 32'd0);
        chk("reset_valid", 32'(valid), 32'd0);

        // Plan 2: basic word 1,0,1,1 -> 4'b1101
        send(4'b1101, 1'b0);
        chk("basic_q", 32'(q), 32'hD);
        chk("basic_valid", 32'(valid), 32'd1);
        chk("basic_cnt", 32'(bit_cnt), 32'd0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("held_q", 32'(q), 32'hD);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("accept_valid", 32'(valid), 32'd0);

        // Plan 3: gapped shift 0,1 | gap | 1,0 -> 4'b0110
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("gap_cnt", 32'(bit_cnt), 32'd2);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("gap_q", 32'(q), 32'h6);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Plan 4: back-to-back with ready held high
        send(4'b1111, 1'b1);
        chk("b2b_q1", 32'(q), 32'hF);
        send(4'b1000, 1'b1);
        chk("b2b_q2", 32'(q), 32'h8);
        chk("b2b_valid", 32'(valid), 32'd1);
        chk("b2b_overrun", 32'(overrun), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Plan 5: overrun, A=0011 then B=1010 with ready low
        send(4'b0011, 1'b0);
        send(4'b1010, 1'b0);
        chk("ovr_q", 32'(q), 32'hA);
        chk("ovr_flag", 32'(overrun), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr_cleared", 32'(overrun), 32'd0);

        // Plan 6: pending word survives resync; pre-resync bits discarded
        send(4'b0101, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("resync_cnt", 32'(bit_cnt), 32'd0);
        chk("resync_pending_q", 32'(q), 32'h5);
        chk("resync_pending_valid", 32'(valid), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send(4'b1010, 1'b0);
        chk("resync_q", 32'(q), 32'hA);
        chk("resync_overrun", 32'(overrun), 32'd0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 9) < 7),
                1'($urandom),
                ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 9) < 4));
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
